step_sequencer: RTL and testbench
=================================

# step_sequencer

Microprogram sequencer for the picoRISC control unit. It holds the current microstep and decodes it into the one-hot step vector `T[255:0]`. Each cycle it selects the next step from the branch strobes and branch-target vector that the control-translation logic derives from `T`. It closes the control loop: the translation logic consumes `T` and produces the branch strobes, and this block consumes those strobes and produces `T`.

## Interface

- Parameters: none. Widths are fixed by the shared control package: 8-bit step, 256 steps.
- `clk`  in  1  system clock. All state changes on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `hold`  in  1  freezes the step counter, e.g. during a memory wait. Highest priority after `rst`.
- `bropr`  in  1  multiway branch on opcode; target is `opr_target`.
- `bradr`  in  1  multiway branch on addressing mode; target is `adr_target`.
- `bruncnd`  in  1  unconditional branch; target is encoded from `signals`.
- `brcnd`  in  1  conditional branch, already qualified (1 = taken); target is encoded from `signals`.
- `signals`  in  16  one-hot branch-target select.
  - Bit 15→0, 14→9, 13→17, 12→19, 11→41, 10→49.
  - Bits 9..0 are reserved and ignored.
- `opr_target`  in  8  step address from the opcode decoder.
- `adr_target`  in  8  step address from the addressing-mode decoder.
- `step`  out  8  current microstep (registered).
- `T`  out  256  one-hot decode of `step`: `T[step]`=1, all other bits 0.
- `sel_err`  out  1  sticky flag: a taken `signals` branch had more than one bit set in 15..10, or had none set.

## Operation

- Next-step priority, evaluated every cycle:
  1. `rst`: step←0 and `sel_err`←0.
  2. `hold`: step unchanged.
  3. `bropr`: step←`opr_target`.
  4. `bradr`: step←`adr_target`.
  5. `bruncnd` or `brcnd`: step←enc(`signals`).
  6. Otherwise: step←step+1.
- enc(`signals`):
  - Priority encoder over bits 15..10; the highest set bit wins.
  - If no bit in 15..10 is set, the target is 0.
- `sel_err` sets when all of the following hold on the same edge:
  - branch 5 is the selected action (not masked by `hold`, `bropr` or `bradr`);
  - bits 15..10 of `signals` are not exactly one-hot.
  - Once set, `sel_err` stays set until `rst`.
- Increment is modulo 256: step 255 + 1 → 0. No error is raised on wrap.
- Strobes that are masked by a higher-priority event are ignored. They are not queued or remembered.
- Targets are not range-checked. Any 8-bit value is legal.

## Timing

- Reset values: `step`=0, `T`=256'h1 (only `T[0]`=1), `sel_err`=0. These are visible the cycle after `rst` is sampled high.
- `T` is a pure combinational decode of the `step` register. It changes only after a clock edge, never within a cycle from the inputs.
- All branch inputs are sampled at the rising edge; the new step is visible the following cycle, so branch latency is one cycle. There is no combinational path from any input to `step` or `T`.
- Combinational path from `T` through the translation logic to the branch inputs: that loop must close within one cycle, so input-to-register logic is kept to the priority mux and the 6-bit encoder.
- `rst` mid-branch: reset wins. Pending strobes in that cycle are discarded.
- `hold` together with a strobe: the strobe is lost. The translation logic re-issues it because `T` is unchanged.

## Structure

- Shared package (`control_pkg`):
  - `STEP_W`=8 and `NSTEPS`=256;
  - the target constants `TGT_0`, `TGT_9`, `TGT_17`, `TGT_19`, `TGT_41`, `TGT_49`;
  - the `signals` bit-index constants 15..10.
- One natural sub-module: `step_decoder`, an 8→256 one-hot decoder that drives `T`.
- Top level contains the step register, the priority next-step mux, the target encoder and the `sel_err` register.

## Test plan

- Reset then sequential stepping: assert `rst` for 1 cycle → `step`=0, `T`=256'h1, `sel_err`=0. With no strobes for 5 cycles → `step`=5 and `T[5]`=1.
- Unconditional branch: at step 11, `bruncnd`=1 and `signals`=16'h1000 → next `step`=19 and `T[19]`=1.
- Priority: `bropr`=1 with `opr_target`=8'h60, plus `bradr`=1 and `bruncnd`=1 → `step`=8'h60. Repeat with `hold`=1 → `step` is unchanged.
- Wrap: `bradr`=1 with `adr_target`=8'hFF → `step`=255. Next cycle with no strobe → `step`=0 and `T[0]`=1.
- Bad select: `brcnd`=1 with `signals`=16'hC000 → `step`=0 (bit 15 wins) and `sel_err`=1. `sel_err` remains 1 through 10 normal cycles and clears only on `rst`.
- Reset mid-operation: at step 41, assert `rst` together with `bruncnd`=1 and `signals`=16'h0400 → `step`=0, not 49.

Source files
------------

// File: rtl/control_pkg.sv
// Purpose: shared widths, branch-target constants and select helpers for the control unit.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package control_pkg;

  localparam int STEP_W = 8;
  localparam int NSTEPS = 256;

  // Fixed microstep entry points reachable through the one-hot signals select.
  localparam logic [STEP_W-1:0] TGT_0  = 8'd0;
  localparam logic [STEP_W-1:0] TGT_9  = 8'd9;
  localparam logic [STEP_W-1:0] TGT_17 = 8'd17;
  localparam logic [STEP_W-1:0] TGT_19 = 8'd19;
  localparam logic [STEP_W-1:0] TGT_41 = 8'd41;
  localparam logic [STEP_W-1:0] TGT_49 = 8'd49;

  // Bit positions inside signals that select the targets above.
  localparam int SIG_B15 = 15;
  localparam int SIG_B14 = 14;
  localparam int SIG_B13 = 13;
  localparam int SIG_B12 = 12;
  localparam int SIG_B11 = 11;
  localparam int SIG_B10 = 10;

  localparam int SEL_W = SIG_B15 - SIG_B10 + 1;

  // Which source feeds the step register this cycle.
  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_HOLD,
    ACT_OPR,
    ACT_ADR,
    ACT_SIG,
    ACT_INC
  } step_act_e;

  // Priority encoder over the select field; the highest set bit wins, none set gives TGT_0.
  // sel[SEL_W-1] corresponds to signals bit 15.
  function automatic logic [STEP_W-1:0] enc_target(input logic [SEL_W-1:0] sel);
    logic [STEP_W-1:0] tgt;
    if (sel[SIG_B15 - SIG_B10])      tgt = TGT_0;
    else if (sel[SIG_B14 - SIG_B10]) tgt = TGT_9;
    else if (sel[SIG_B13 - SIG_B10]) tgt = TGT_17;
    else if (sel[SIG_B12 - SIG_B10]) tgt = TGT_19;
    else if (sel[SIG_B11 - SIG_B10]) tgt = TGT_41;
    else if (sel[SIG_B10 - SIG_B10]) tgt = TGT_49;
    else                             tgt = TGT_0;
    return tgt;
  endfunction

  // A well-formed select has exactly one bit set.
  function automatic logic sel_is_onehot(input logic [SEL_W-1:0] sel);
    return $onehot(sel);
  endfunction

endpackage

// File: rtl/step_decoder.sv
// Purpose: 8-to-256 one-hot decoder turning the current microstep into the T vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input step.
module step_decoder
  import control_pkg::*;
(
  input  logic [STEP_W-1:0] step,
  output logic [NSTEPS-1:0] T
);

  // Exactly one T bit is set: the one indexed by step.
  always_comb begin
    T       = '0;
    T[step] = 1'b1;
  end

endmodule

// File: rtl/step_sequencer.sv
// Purpose: microprogram sequencer; holds the microstep, picks the next one from branch strobes.
// Latency: one cycle from strobe sample to new step/T; T is decoded from the register only.
// Backpressure: hold freezes the step; strobes masked by hold or higher priority are dropped.
module step_sequencer
  import control_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              bropr,
  input  logic              bradr,
  input  logic              bruncnd,
  input  logic              brcnd,
  input  logic [15:0]       signals,
  input  logic [STEP_W-1:0] opr_target,
  input  logic [STEP_W-1:0] adr_target,
  output logic [STEP_W-1:0] step,
  output logic [NSTEPS-1:0] T,
  output logic              sel_err
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              sel_err_q, sel_err_d;
  step_act_e         act;
  logic [SEL_W-1:0]  sel;
  logic [STEP_W-1:0] sig_target;
  logic              sel_bad;

  // Low signals bits are reserved; fold them away so they do not look like dropped logic.
  logic unused_sig;
  assign unused_sig = ^signals[SIG_B10-1:0];

  assign sel        = signals[SIG_B15:SIG_B10];
  assign sig_target = enc_target(sel);
  assign sel_bad    = !sel_is_onehot(sel);

  // Resolve the next-step source in fixed priority order.
  always_comb begin
    act = ACT_INC;
    if (rst)                    act = ACT_RESET;
    else if (hold)              act = ACT_HOLD;
    else if (bropr)             act = ACT_OPR;
    else if (bradr)             act = ACT_ADR;
    else if (bruncnd || brcnd)  act = ACT_SIG;
    else                        act = ACT_INC;
  end

  // Next-step mux and sticky select-error update; increment wraps naturally at 8 bits.
  always_comb begin
    step_d    = step_q + 8'd1;
    sel_err_d = sel_err_q;
    unique case (act)
      ACT_RESET: begin
        step_d    = TGT_0;
        sel_err_d = 1'b0;
      end
      ACT_HOLD:  step_d = step_q;
      ACT_OPR:   step_d = opr_target;
      ACT_ADR:   step_d = adr_target;
      ACT_SIG: begin
        step_d = sig_target;
        if (sel_bad) sel_err_d = 1'b1;
      end
      ACT_INC:   step_d = step_q + 8'd1;
      default:   step_d = step_q + 8'd1;
    endcase
  end

  // Step and error registers; synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      step_q    <= step_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign step    = step_q;
  assign sel_err = sel_err_q;

  step_decoder u_step_decoder (
    .step (step_q),
    .T    (T)
  );

endmodule

// File: tb/tb_step_sequencer.sv
// Purpose: scoreboard bench for step_sequencer against a behavioural next-step model.
// Latency: expects each sampled set of inputs to show up in step/T/sel_err one cycle later.
// Backpressure: none; the DUT presents a result every cycle after stimulus starts.
module tb_step_sequencer;

  logic         clk = 1'b0;
  logic         rst, hold, bropr, bradr, bruncnd, brcnd;
  logic [15:0]  signals;
  logic [7:0]   opr_target, adr_target;
  logic [7:0]   step;
  logic [255:0] T;
  logic         sel_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int step;
    bit err;
  } exp_t;

  exp_t exp_q[$];

  // Reference state, kept as plain integers.
  int m_step = 0;
  bit m_err  = 1'b0;

  // signals bit -> target table.
  int tbl_bit[6] = '{15, 14, 13, 12, 11, 10};
  int tbl_tgt[6] = '{0, 9, 17, 19, 41, 49};

  always #5 clk = ~clk;

  step_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .bropr      (bropr),
    .bradr      (bradr),
    .bruncnd    (bruncnd),
    .brcnd      (brcnd),
    .signals    (signals),
    .opr_target (opr_target),
    .adr_target (adr_target),
    .step       (step),
    .T          (T),
    .sel_err    (sel_err)
  );

  // Apply one cycle of inputs, predict the resulting state, queue it, wait for the edge.
  task automatic drive(input bit r, input bit h, input bit bo, input bit ba,
                       input bit bu, input bit bc, input logic [15:0] sg,
                       input int ot, input int at);
    exp_t e;
    int   nset;
    int   tgt;
    rst = r; hold = h; bropr = bo; bradr = ba; bruncnd = bu; brcnd = bc;
    signals = sg; opr_target = 8'(ot); adr_target = 8'(at);
    if (r) begin
      m_step = 0;
      m_err  = 1'b0;
    end else if (h) begin
      m_step = m_step;
    end else if (bo) begin
      m_step = ot;
    end else if (ba) begin
      m_step = at;
    end else if (bu || bc) begin
      nset = 0;
      tgt  = -1;
      for (int i = 0; i < 6; i++) begin
        if (sg[tbl_bit[i]]) begin
          nset++;
          if (tgt < 0) tgt = tbl_tgt[i];
        end
      end
      m_step = (tgt < 0) ? 0 : tgt;
      if (nset != 1) m_err = 1'b1;
    end else begin
      m_step = (m_step + 1) % 256;
    end
    e.step = m_step;
    e.err  = m_err;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 16'h0, 0, 0);
  endtask

  // Monitor: one result per cycle, checked 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (int'(step) != e.step) begin
          errors++;
          $display("FAIL step: got %0d expected %0d at %0t", step, e.step, $time);
        end
        checks++;
        if (!(T[e.step[7:0]] === 1'b1 && $countones(T) == 1)) begin
          errors++;
          $display("FAIL T_onehot: got %h expected only bit %0d set", T, e.step);
        end
        checks++;
        if (sel_err !== e.err) begin
          errors++;
          $display("FAIL sel_err: got %0b expected %0b at %0t", sel_err, e.err, $time);
        end
      end
    end
  end

  // Stimulus: directed sequences first, then randomized traffic.
  initial begin
    logic [15:0] sg;
    int          k;
    rst = 1'b0; hold = 1'b0; bropr = 1'b0; bradr = 1'b0; bruncnd = 1'b0; brcnd = 1'b0;
    signals = 16'h0; opr_target = 8'h0; adr_target = 8'h0;
    @(posedge clk);
    #2;

    // Reset, then free-running increment to 5, then on to 11.
    drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    idle(5);
    idle(6);
    // Unconditional branch with bit 12 -> 19.
    drive(0, 0, 0, 0, 1, 0, 16'h1000, 0, 0);
    // Priority: opcode branch beats the others; then hold beats everything.
    drive(0, 0, 1, 1, 1, 0, 16'h8000, 8'h60, 8'h22);
    drive(0, 1, 1, 1, 1, 0, 16'h8000, 8'h33, 8'h22);
    // Wrap from 255 to 0.
    drive(0, 0, 0, 1, 0, 0, 16'h0, 0, 8'hFF);
    idle(1);
    // Two bits set: bit 15 wins and the error sticks.
    drive(0, 0, 0, 0, 0, 1, 16'hC000, 0, 0);
    idle(10);
    drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    // Empty select is also an error; reserved bits alone do not count.
    drive(0, 0, 0, 0, 1, 0, 16'h03FF, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 16'h0, 0, 0);
    // Error-worthy select masked by bradr must not set the flag.
    drive(0, 0, 0, 1, 0, 1, 16'hC000, 0, 8'd41);
    // Reset wins over a simultaneous branch from step 41.
    drive(1, 0, 0, 0, 1, 0, 16'h0400, 0, 0);
    // Each single-bit select once.
    for (int i = 0; i < 6; i++) begin
      sg = 16'h0;
      sg[tbl_bit[i]] = 1'b1;
      drive(0, 0, 0, 0, (i % 2) == 0, (i % 2) == 1, sg, 0, 0);
    end

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      k = $urandom_range(0, 3);
      sg = 16'($urandom);
      if (k != 0) begin
        sg[15:10] = 6'h0;
        sg[$urandom_range(10, 15)] = 1'b1;
      end
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 5) == 0,
            sg, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
